// File: rtl/nrisk_pkg.sv
// rtl/nrisk_pkg.sv - shared constants and enums for the 8-bit core fetch path
package nrisk_pkg;

  localparam int          ADDR_W    = 8;
  localparam int          DATA_W    = 8;
  localparam logic [ADDR_W-1:0] RESET_VEC = 8'h00;
  localparam int          MAX_WAIT  = 15;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    STOP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_INC    = 2'd1,
    PC_BRANCH = 2'd2
  } pc_sel_e;

endpackage

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - program counter register with hold / increment / load select
module pc_reg
  import nrisk_pkg::*;
#(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  pc_sel_e      i_sel,
  input  logic [W-1:0] i_load,
  output logic [W-1:0] o_pc
);

  logic [W-1:0] r_pc;
  logic [W-1:0] w_pc_nxt;

  // Increment wraps naturally at 2^W.
  always_comb begin
    w_pc_nxt = r_pc;
    case (i_sel)
      PC_INC:    w_pc_nxt = r_pc + W'(1);
      PC_BRANCH: w_pc_nxt = i_load;
      default:   w_pc_nxt = r_pc;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc <= RST_VAL;
    end else begin
      r_pc <= w_pc_nxt;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch FSM: issues reads at the PC, holds the instruction
// for decode, advances the PC, and stops the core on a memory timeout.
module pc_sequencer #(
  parameter int                  ADDR_W    = nrisk_pkg::ADDR_W,
  parameter int                  DATA_W    = nrisk_pkg::DATA_W,
  parameter logic [ADDR_W-1:0]   RESET_VEC = nrisk_pkg::RESET_VEC,
  parameter int                  MAX_WAIT  = nrisk_pkg::MAX_WAIT
) (
  input  logic              clock,
  input  logic              resetN,
  output logic              memReq,
  output logic [ADDR_W-1:0] memAddr,
  input  logic              memAck,
  input  logic [DATA_W-1:0] memData,
  output logic              instrValid,
  output logic [DATA_W-1:0] instr,
  input  logic              instrAccept,
  input  logic              branchTaken,
  input  logic [ADDR_W-1:0] branchTarget,
  input  logic              haltReq,
  output logic [ADDR_W-1:0] pcAtual,
  output logic              halted,
  output logic              memFault
);

  import nrisk_pkg::*;

  localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [WAIT_W-1:0]   r_wait;
  logic [WAIT_W-1:0]   w_wait_nxt;
  logic [DATA_W-1:0]   r_instr;
  logic                r_instr_valid;
  logic                r_halted;
  logic                r_mem_fault;
  pc_sel_e             w_pc_sel;
  logic                w_ld_instr;
  logic                w_set_halt;
  logic                w_set_fault;
  logic [ADDR_W-1:0]   w_pc;

  pc_reg #(
    .W       (ADDR_W),
    .RST_VAL (RESET_VEC)
  ) u_pc_reg (
    .i_clk   (clock),
    .i_rst_n (resetN),
    .i_sel   (w_pc_sel),
    .i_load  (branchTarget),
    .o_pc    (w_pc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    w_pc_sel    = PC_HOLD;
    w_ld_instr  = 1'b0;
    w_set_halt  = 1'b0;
    w_set_fault = 1'b0;
    case (r_state)
      BOOT: w_state_nxt = FETCH;
      FETCH: begin
        // An ack arriving on the last allowed cycle still completes the fetch.
        if (memAck) begin
          w_ld_instr  = 1'b1;
          w_wait_nxt  = '0;
          w_state_nxt = HOLD;
        end else if (r_wait == WAIT_LAST) begin
          w_set_fault = 1'b1;
          w_set_halt  = 1'b1;
          w_wait_nxt  = r_wait + WAIT_W'(1);
          w_state_nxt = STOP;
        end else begin
          w_wait_nxt  = r_wait + WAIT_W'(1);
        end
      end
      HOLD: begin
        if (instrAccept) begin
          if (haltReq) begin
            w_set_halt  = 1'b1;
            w_state_nxt = STOP;
          end else if (branchTaken) begin
            w_pc_sel    = PC_BRANCH;
            w_state_nxt = FETCH;
          end else begin
            w_pc_sel    = PC_INC;
            w_state_nxt = FETCH;
          end
        end
      end
      STOP:    w_state_nxt = STOP;
      default: w_state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state       <= BOOT;
      r_wait        <= '0;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
      r_mem_fault   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wait        <= w_wait_nxt;
      r_instr_valid <= (w_state_nxt == HOLD);
      if (w_ld_instr)  r_instr     <= memData;
      if (w_set_halt)  r_halted    <= 1'b1;
      if (w_set_fault) r_mem_fault <= 1'b1;
    end
  end

  assign memReq     = (r_state == FETCH);
  assign memAddr    = w_pc;
  assign pcAtual    = w_pc;
  assign instrValid = r_instr_valid;
  assign instr      = r_instr;
  assign halted     = r_halted;
  assign memFault   = r_mem_fault;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed and randomized fetch transactions against a
// transaction-level model of the PC, instruction and halt/fault state.
module tb_pc_sequencer;

  logic       clock = 1'b0;
  logic       resetN;
  logic       memReq;
  logic [7:0] memAddr;
  logic       memAck;
  logic [7:0] memData;
  logic       instrValid;
  logic [7:0] instr;
  logic       instrAccept;
  logic       branchTaken;
  logic [7:0] branchTarget;
  logic       haltReq;
  logic [7:0] pcAtual;
  logic       halted;
  logic       memFault;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] m_pc;
  logic [7:0] m_instr;
  logic       m_fault;

  pc_sequencer dut (
    .clock        (clock),
    .resetN       (resetN),
    .memReq       (memReq),
    .memAddr      (memAddr),
    .memAck       (memAck),
    .memData      (memData),
    .instrValid   (instrValid),
    .instr        (instr),
    .instrAccept  (instrAccept),
    .branchTaken  (branchTaken),
    .branchTarget (branchTarget),
    .haltReq      (haltReq),
    .pcAtual      (pcAtual),
    .halted       (halted),
    .memFault     (memFault)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"},     pcAtual,    32'h00);
    chk({tag, "_req"},    memReq,     32'h0);
    chk({tag, "_valid"},  instrValid, 32'h0);
    chk({tag, "_instr"},  instr,      32'h00);
    chk({tag, "_halted"}, halted,     32'h0);
    chk({tag, "_fault"},  memFault,   32'h0);
  endtask

  // Reset with a stale ack on the bus; BOOT must ignore it, then FETCH at RESET_VEC.
  task automatic do_reset();
    resetN = 1'b0;
    memAck = 1'b1;
    memData = 8'($urandom);
    #1;
    chk_reset_vals("rst");
    step();
    step();
    chk_reset_vals("rst_held");
    resetN = 1'b1;
    m_pc = 8'h00;
    m_instr = 8'h00;
    m_fault = 1'b0;
    chk("boot_req", memReq, 32'h0);
    step();
    memAck = 1'b0;
    chk("boot_to_fetch_req", memReq, 32'h1);
    chk("boot_to_fetch_addr", memAddr, 32'h00);
    chk("boot_ack_ignored", instrValid, 32'h0);
  endtask

  // Starts in FETCH; ack after dly missed cycles with word d.
  task automatic do_fetch(input int dly, input logic [7:0] d);
    for (int i = 0; i < dly; i++) begin
      memAck = 1'b0;
      memData = 8'($urandom);
      instrAccept = 1'($urandom);
      branchTaken = 1'($urandom);
      haltReq = 1'($urandom);
      branchTarget = 8'($urandom);
      chk("fetch_req", memReq, 32'h1);
      chk("fetch_addr", memAddr, 32'(m_pc));
      chk("fetch_nvalid", instrValid, 32'h0);
      chk("fetch_nfault", memFault, 32'h0);
      step();
    end
    chk("ack_req", memReq, 32'h1);
    chk("ack_addr", memAddr, 32'(m_pc));
    memAck = 1'b1;
    memData = d;
    step();
    memAck = 1'b0;
    instrAccept = 1'b0;
    branchTaken = 1'b0;
    haltReq = 1'b0;
    m_instr = d;
    chk("hold_valid", instrValid, 32'h1);
    chk("hold_instr", instr, 32'(m_instr));
    chk("hold_req", memReq, 32'h0);
    chk("hold_nfault", memFault, 32'h0);
  endtask

  // Starts in HOLD; stalls for waits cycles, then accepts with the given decode outcome.
  task automatic do_hold(input int waits, input bit br, input logic [7:0] tgt, input bit hlt);
    for (int i = 0; i < waits; i++) begin
      instrAccept = 1'b0;
      branchTaken = 1'($urandom);
      haltReq = 1'($urandom);
      branchTarget = 8'($urandom);
      memAck = 1'($urandom);
      memData = 8'($urandom);
      step();
      chk("stall_valid", instrValid, 32'h1);
      chk("stall_instr", instr, 32'(m_instr));
      chk("stall_pc", pcAtual, 32'(m_pc));
      chk("stall_req", memReq, 32'h0);
    end
    memAck = 1'b0;
    instrAccept = 1'b1;
    branchTaken = br;
    branchTarget = tgt;
    haltReq = hlt;
    step();
    instrAccept = 1'b0;
    branchTaken = 1'b0;
    haltReq = 1'b0;
    if (hlt) begin
      chk("halt_halted", halted, 32'h1);
      chk("halt_valid", instrValid, 32'h0);
      chk("halt_req", memReq, 32'h0);
      chk("halt_pc", pcAtual, 32'(m_pc));
    end else begin
      m_pc = br ? tgt : m_pc + 8'd1;
      chk("next_req", memReq, 32'h1);
      chk("next_addr", memAddr, 32'(m_pc));
      chk("next_valid", instrValid, 32'h0);
      chk("next_halted", halted, 32'h0);
    end
  endtask

  task automatic stop_check(input int n);
    for (int i = 0; i < n; i++) begin
      memAck = 1'($urandom);
      memData = 8'($urandom);
      instrAccept = 1'($urandom);
      branchTaken = 1'($urandom);
      haltReq = 1'($urandom);
      branchTarget = 8'($urandom);
      step();
      chk("stop_halted", halted, 32'h1);
      chk("stop_req", memReq, 32'h0);
      chk("stop_valid", instrValid, 32'h0);
      chk("stop_pc", pcAtual, 32'(m_pc));
      chk("stop_instr", instr, 32'(m_instr));
      chk("stop_fault", memFault, 32'(m_fault));
    end
    memAck = 1'b0;
    instrAccept = 1'b0;
    branchTaken = 1'b0;
    haltReq = 1'b0;
  endtask

  initial begin
    resetN = 1'b0;
    memAck = 1'b0;
    memData = 8'h00;
    instrAccept = 1'b0;
    branchTaken = 1'b0;
    branchTarget = 8'h00;
    haltReq = 1'b0;
    m_pc = 8'h00;
    m_instr = 8'h00;
    m_fault = 1'b0;

    do_reset();
    do_fetch(0, 8'hA5);
    do_hold(0, 1'b0, 8'h00, 1'b0);
    chk("first_inc_addr", memAddr, 32'h01);

    do_fetch(3, 8'h3C);
    do_hold(5, 1'b0, 8'h00, 1'b0);
    do_fetch(1, 8'h11);
    do_hold(0, 1'b1, 8'h40, 1'b0);
    chk("branch_addr", memAddr, 32'h40);

    do_fetch(14, 8'h5A);
    do_hold(1, 1'b0, 8'h00, 1'b0);

    for (int t = 0; t < 20; t++) begin
      do_fetch(int'($urandom_range(0, 14)), 8'($urandom));
      do_hold(int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), 8'($urandom), 1'b0);
    end

    do_fetch(0, 8'h77);
    do_hold(0, 1'b1, 8'hFF, 1'b0);
    do_fetch(2, 8'h88);
    do_hold(0, 1'b0, 8'h00, 1'b0);
    chk("wrap_pc", pcAtual, 32'h00);
    chk("wrap_addr", memAddr, 32'h00);

    do_fetch(0, 8'hC3);
    do_hold(2, 1'b1, 8'h99, 1'b1);
    stop_check(4);

    do_reset();
    do_fetch(0, 8'h12);
    do_hold(0, 1'b1, 8'h77, 1'b0);
    for (int i = 0; i < 7; i++) begin
      chk("pre_pulse_req", memReq, 32'h1);
      step();
    end
    resetN = 1'b0;
    memAck = 1'b1;
    #1;
    chk_reset_vals("pulse");
    #2;
    resetN = 1'b1;
    m_pc = 8'h00;
    m_instr = 8'h00;
    chk("pulse_boot_req", memReq, 32'h0);
    step();
    memAck = 1'b0;
    chk("pulse_ack_ignored", instrValid, 32'h0);
    for (int i = 0; i < 15; i++) begin
      memData = 8'($urandom);
      instrAccept = 1'($urandom);
      chk("wd_req", memReq, 32'h1);
      chk("wd_addr", memAddr, 32'h00);
      chk("wd_nfault", memFault, 32'h0);
      step();
    end
    instrAccept = 1'b0;
    m_fault = 1'b1;
    chk("wd_fault", memFault, 32'h1);
    chk("wd_halted", halted, 32'h1);
    chk("wd_req_off", memReq, 32'h0);
    stop_check(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
